// File: rtl/sqrt_pkg.sv
// Shared definitions for the odd-step integer square-root unit:
// controller state codes and the algorithm's fixed constants.
package sqrt_pkg;

  typedef enum logic [3:0] {
    idle          = 4'd0,
    getX          = 4'd1,
    compara       = 4'd2,
    sumD_loadR1   = 4'd3,
    sumD_loadR2   = 4'd4,
    sumD_drive    = 4'd5,
    sumS_loadR1   = 4'd6,
    sumS_loadR2_1 = 4'd7,
    sumS_driveR1  = 4'd8,
    sumS_loadR2_2 = 4'd9,
    sumS_drive    = 4'd10,
    zero          = 4'd11,
    finaliza      = 4'd12
  } State;

  localparam logic [8:0] D_INIT = 9'd2;
  localparam logic [8:0] S_INIT = 9'd4;
  localparam logic [8:0] D_STEP = 9'd2;
  localparam logic [8:0] S_BIAS = 9'd1;

endpackage

// File: rtl/sqrt_datapath_reg.sv
// 9-bit register with asynchronous active-low clear and load enable,
// used for the d, s, r1 and r2 registers of the square-root datapath.
module sqrt_datapath_reg (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       en_i,
  input  logic [8:0] d_i,
  output logic [8:0] q_o
);

  logic [8:0] r_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   r_q <= '0;
    else if (en_i) r_q <= d_i;
  end

  assign q_o = r_q;

endmodule

// File: rtl/sqrt_datapath.sv
// Datapath of the iterative 8-bit square root: d/s/x registers, the two
// adder operand registers and the result/done outputs, driven by State.
module sqrt_datapath
  import sqrt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       enb_i,
  input  State       state_i,
  input  logic [7:0] x_i,
  output logic [8:0] d_o,
  output logic [8:0] s_o,
  output logic [7:0] x_o,
  output logic [3:0] result_o,
  output logic       done_o
);

  logic [8:0] w_d, w_s, w_r1, w_r2;
  logic [8:0] w_sum;
  logic       w_d_en, w_s_en, w_r1_en, w_r2_en;
  logic [8:0] w_d_nxt, w_s_nxt, w_r1_nxt, w_r2_nxt;

  logic [7:0] r_x;
  logic [3:0] r_result;
  logic       r_done;

  // Single shared adder; wraps modulo 512 (never reached for 8-bit x).
  assign w_sum = w_r1 + w_r2;

  always_comb begin
    w_d_en   = 1'b0;
    w_s_en   = 1'b0;
    w_r1_en  = 1'b0;
    w_r2_en  = 1'b0;
    w_d_nxt  = w_sum;
    w_s_nxt  = w_sum;
    w_r1_nxt = w_sum;
    w_r2_nxt = D_STEP;
    case (state_i)
      getX: begin
        w_d_en  = 1'b1;
        w_s_en  = 1'b1;
        w_d_nxt = D_INIT;
        w_s_nxt = S_INIT;
      end
      sumD_loadR1: begin
        w_r1_en  = 1'b1;
        w_r1_nxt = w_d;
      end
      sumD_loadR2: begin
        w_r2_en  = 1'b1;
        w_r2_nxt = D_STEP;
      end
      sumD_drive:   w_d_en = 1'b1;
      sumS_loadR1: begin
        w_r1_en  = 1'b1;
        w_r1_nxt = w_s;
      end
      sumS_loadR2_1: begin
        w_r2_en  = 1'b1;
        w_r2_nxt = w_d;
      end
      sumS_driveR1: w_r1_en = 1'b1;
      sumS_loadR2_2: begin
        w_r2_en  = 1'b1;
        w_r2_nxt = S_BIAS;
      end
      sumS_drive:   w_s_en = 1'b1;
      default: ;
    endcase
  end

  sqrt_datapath_reg u_d (
    .clk_i (clk_i), .rstn_i(rstn_i), .en_i(enb_i & w_d_en),
    .d_i   (w_d_nxt), .q_o(w_d)
  );

  sqrt_datapath_reg u_s (
    .clk_i (clk_i), .rstn_i(rstn_i), .en_i(enb_i & w_s_en),
    .d_i   (w_s_nxt), .q_o(w_s)
  );

  sqrt_datapath_reg u_r1 (
    .clk_i (clk_i), .rstn_i(rstn_i), .en_i(enb_i & w_r1_en),
    .d_i   (w_r1_nxt), .q_o(w_r1)
  );

  sqrt_datapath_reg u_r2 (
    .clk_i (clk_i), .rstn_i(rstn_i), .en_i(enb_i & w_r2_en),
    .d_i   (w_r2_nxt), .q_o(w_r2)
  );

  // done pulses only in the enabled cycle following finaliza/zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_x      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else if (enb_i) begin
      r_done <= 1'b0;
      case (state_i)
        getX:     r_x <= x_i;
        finaliza: begin
          r_result <= w_d[4:1];
          r_done   <= 1'b1;
        end
        zero: begin
          r_result <= '0;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign d_o      = w_d;
  assign s_o      = w_s;
  assign x_o      = r_x;
  assign result_o = r_result;
  assign done_o   = r_done;

endmodule
